// File: rtl/bram_port_pkg.sv
// Shared types and constants for the bram_port request sequencer.
package bram_port_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        CAP,
        WR
    } state_e;

    // Size code 3 is treated as a full word, so only the upper bit matters.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/bram_port_align.sv
// Combinational lane logic: load extraction/extension and sub-word store merge.
module bram_port_align
    import bram_port_pkg::*;
(
    input  logic [DATA_W-1:0] bram_out,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] merged
);

    always_comb begin
        rdata  = bram_out;
        merged = wdata;
        case (size)
            SIZE_B: begin
                rdata  = {{24{sign_ext & bram_out[7]}}, bram_out[7:0]};
                merged = {bram_out[31:8], wdata[7:0]};
            end
            SIZE_H: begin
                rdata  = {{16{sign_ext & bram_out[15]}}, bram_out[15:0]};
                merged = {bram_out[31:16], wdata[15:0]};
            end
            default: begin
                rdata  = bram_out;
                merged = wdata;
            end
        endcase
    end

endmodule

// File: rtl/bram_port.sv
// Load/store sequencer in front of a byte-addressed unaligned word RAM.
// Define BRAM_PORT_FAST_STORE_EN to let word stores write straight from IDLE.
module bram_port
    import bram_port_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [ADDR_WIDTH-1:0] bram_raddr,
    output logic [ADDR_WIDTH-1:0] bram_waddr,
    output logic [DATA_W-1:0]     bram_wdata,
    output logic                  bram_wren,
    input  logic [DATA_W-1:0]     bram_out
);

    state_e                state, state_nx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic                  write_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     merged_q;
    logic [DATA_W-1:0]     ext_rdata;
    logic [DATA_W-1:0]     merged;
    logic                  accept;
    logic                  fast_wr;

    bram_port_align u_align (
        .bram_out (bram_out),
        .size     (size_q),
        .sign_ext (signed_q),
        .wdata    (wdata_q),
        .rdata    (ext_rdata),
        .merged   (merged)
    );

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

`ifdef BRAM_PORT_FAST_STORE_EN
    assign fast_wr = accept && req_write && is_word(req_size);
`else
    assign fast_wr = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!req_write || !is_word(req_size))
                        state_nx = RD;
                    else if (!fast_wr)
                        state_nx = WR;
                end
            end
            RD:      state_nx = CAP;
            CAP:     state_nx = write_q ? WR : IDLE;
            WR:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            signed_q  <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            merged_q  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nx;
            rsp_valid <= (state == CAP) && !write_q;
            if (accept) begin
                addr_q   <= req_addr;
                size_q   <= req_size;
                signed_q <= req_signed;
                write_q  <= req_write;
                wdata_q  <= req_wdata;
            end
            if (state == CAP) begin
                if (write_q)
                    merged_q <= merged;
                else
                    rsp_rdata <= ext_rdata;
            end
        end
    end

    // Fast path bypasses the request registers; otherwise the RAM sees latched values.
    assign bram_raddr = addr_q;
    assign bram_waddr = fast_wr ? req_addr : addr_q;
    assign bram_wdata = fast_wr ? req_wdata : (is_word(size_q) ? wdata_q : merged_q);
    assign bram_wren  = (state == WR) || fast_wr;

endmodule

// File: tb/tb_bram_port.sv
// Randomized self-checking bench for bram_port with a byte-array RAM and reference memory.
module tb_bram_port;

    localparam int AW    = 11;
    localparam int MEMSZ = 2048;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_write, req_signed;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] bram_raddr, bram_waddr;
    logic [31:0]   bram_wdata, bram_out;
    logic          bram_wren;

    logic [7:0]    ram     [0:MEMSZ-1];
    logic [7:0]    ref_mem [0:MEMSZ-1];
    logic [31:0]   last_rd;
    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    int unsigned   cyc_cnt  = 0;

    bram_port #(.ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .bram_raddr (bram_raddr),
        .bram_waddr (bram_waddr),
        .bram_wdata (bram_wdata),
        .bram_wren  (bram_wren),
        .bram_out   (bram_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    // Unaligned word RAM: 4 bytes little-endian at any address, registered read.
    always @(posedge clock) begin
        logic [31:0]   rd;
        logic [AW-1:0] ix;
        for (int i = 0; i < 4; i++) begin
            ix = bram_raddr + AW'(i);
            rd[8*i +: 8] = ram[ix];
        end
        if (bram_wren) begin
            for (int i = 0; i < 4; i++) begin
                ix = bram_waddr + AW'(i);
                ram[ix] <= bram_wdata[8*i +: 8];
            end
        end
        bram_out <= rd;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [AW-1:0] a, input logic [1:0] sz, input logic sg);
        longint v = 0;
        int     n = nbytes(sz);
        for (int i = 0; i < n; i++)
            v = v + (longint'(ref_mem[(int'(a) + i) % MEMSZ]) << (8 * i));
        if (sg && n < 4 && v[8*n-1])
            v = v + (64'hFFFF_FFFF << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [AW-1:0] a, input logic [1:0] sz, input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++)
            ref_mem[(int'(a) + i) % MEMSZ] = wd[8*i +: 8];
    endtask

    task automatic compare_mem(input string tag);
        for (int i = 0; i < 80; i++)
            check(tag, {24'd0, ram[i]}, {24'd0, ref_mem[i]});
    endtask

    // Call at a negedge with the DUT idle; returns at the negedge where it is idle again.
    // req_valid stays high afterwards and busy-cycle inputs are scrambled.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [AW-1:0] a, input logic [31:0] wd);
        int          t;
        logic        fast;
        logic [31:0] exp_rd, exp_wd;
        fast = 1'b0;
`ifdef BRAM_PORT_FAST_STORE_EN
        fast = wr && sz[1];
`endif
        t = !wr ? 3 : (sz[1] ? (fast ? 1 : 2) : 4);
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        #1;
        check("accept_ready", req_ready, 1);
        if (fast) begin
            check("fast_wren", bram_wren, 1);
            check("fast_waddr", bram_waddr, a);
            check("fast_wdata", bram_wdata, wd);
        end
        @(posedge clock);
        exp_rd = '0;
        exp_wd = '0;
        if (wr) begin
            ref_store(a, sz, wd);
            exp_wd = ref_load(a, 2'd2, 1'b0);
        end else begin
            exp_rd = ref_load(a, sz, sg);
        end
        for (int c = 1; c <= t; c++) begin
            @(negedge clock);
            if (c < t) begin
                check("busy_ready", req_ready, 0);
                check("busy_rspv", rsp_valid, 0);
                if (wr) begin
                    check("wren", bram_wren, (c == t - 1) ? 1 : 0);
                    if (c == t - 1) begin
                        check("waddr", bram_waddr, a);
                        check("wdata", bram_wdata, exp_wd);
                    end
                end else begin
                    check("load_wren", bram_wren, 0);
                end
                req_write  = 1'($urandom);
                req_size   = 2'($urandom);
                req_signed = 1'($urandom);
                req_addr   = AW'($urandom);
                req_wdata  = $urandom;
            end else begin
                check("done_ready", req_ready, 1);
                if (!wr) begin
                    check("rsp_valid", rsp_valid, 1);
                    check("rdata", rsp_rdata, exp_rd);
                    last_rd = exp_rd;
                end else begin
                    check("store_rspv", rsp_valid, 0);
                    check("rdata_hold", rsp_rdata, last_rd);
                end
            end
        end
    endtask

    task automatic go_idle();
        req_valid = 1'b0;
        @(negedge clock);
    endtask

    // Start a store, assert reset after `at` busy cycles, confirm nothing was written.
    task automatic reset_mid(input logic [1:0] sz, input logic [AW-1:0] a, input int at);
        req_write = 1'b1; req_size = sz; req_signed = 1'b0;
        req_addr  = a;    req_wdata = $urandom; req_valid = 1'b1;
        @(posedge clock);
        for (int c = 1; c <= at; c++) begin
            @(negedge clock);
            req_valid = 1'b0;
        end
        reset = 1'b1;
        #1;
        check("rst_wren", bram_wren, 0);
        check("rst_ready", req_ready, 1);
        check("rst_rspv", rsp_valid, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("post_rst_wren", bram_wren, 0);
            check("post_rst_ready", req_ready, 1);
            check("post_rst_rspv", rsp_valid, 0);
        end
        last_rd = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0;
        for (int i = 0; i < MEMSZ; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; last_rd = '0;
        repeat (3) @(negedge clock);
        check("rst_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_wren", bram_wren, 0);
        check("rst_raddr", bram_raddr, 0);
        check("rst_waddr", bram_waddr, 0);
        check("rst_wdata", bram_wdata, 0);
        reset = 1'b0;
        @(negedge clock);

        // word store then word load
        do_req(1'b1, 2'd2, 1'b0, 11'd3, 32'h1234_5678);
        do_req(1'b0, 2'd2, 1'b0, 11'd3, 32'h0);
        check("t1_load", rsp_rdata, 32'h1234_5678);
        go_idle();

        // byte store through read-modify-write
        ram[0] = 8'hDD; ram[1] = 8'hCC; ram[2] = 8'hBB; ram[3] = 8'hAA;
        for (int i = 0; i < 4; i++) ref_mem[i] = ram[i];
        do_req(1'b1, 2'd0, 1'b0, 11'd0, 32'h0000_0011);
        check("t2_ram", {ram[3], ram[2], ram[1], ram[0]}, 32'hAABB_CC11);
        do_req(1'b0, 2'd2, 1'b0, 11'd0, 32'h0);
        check("t2_load", rsp_rdata, 32'hAABB_CC11);
        go_idle();

        // sign and zero extension
        do_req(1'b1, 2'd0, 1'b0, 11'd5, 32'h0000_0080);
        do_req(1'b0, 2'd0, 1'b1, 11'd5, 32'h0);
        check("t3_sbyte", rsp_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 2'd0, 1'b0, 11'd5, 32'h0);
        check("t3_ubyte", rsp_rdata, 32'h0000_0080);
        do_req(1'b1, 2'd1, 1'b0, 11'd5, 32'h0000_8001);
        do_req(1'b0, 2'd1, 1'b1, 11'd5, 32'h0);
        check("t3_shalf", rsp_rdata, 32'hFFFF_8001);
        go_idle();

        // back-to-back loads with valid held
        for (int i = 0; i < 6; i++)
            do_req(1'b0, 2'($urandom), 1'($urandom), AW'($urandom_range(0, 40)), 32'h0);
        go_idle();

        // reset during CAP of a half store, then during WR of a byte store
        reset_mid(2'd1, 11'd20, 2);
        reset_mid(2'd0, 11'd24, 3);
        compare_mem("rst_mem");

        // four word stores back to back
        t0 = cyc_cnt;
        for (int i = 0; i < 4; i++)
            do_req(1'b1, 2'd2, 1'b0, AW'(4 * i), $urandom);
        req_valid = 1'b0;
`ifdef BRAM_PORT_FAST_STORE_EN
        check("t6_cycles", cyc_cnt - t0, 4);
`else
        check("t6_cycles", cyc_cnt - t0, 8);
`endif
        @(negedge clock);

        // random mix
        for (int i = 0; i < 250; i++) begin
            do_req(1'($urandom), 2'($urandom), 1'($urandom),
                   AW'($urandom_range(0, 76)), $urandom);
            if ($urandom_range(0, 3) == 0) go_idle();
        end
        go_idle();
        compare_mem("final_mem");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_port.md
# bram_port

Request sequencer that sits directly upstream of the byte-addressed unaligned block RAM and drives its read and write ports. It accepts one load or store at a time over a valid/ready handshake and supports byte, half and word sizes. Loads are returned zero- or sign-extended. The RAM only writes full 32-bit words, so sub-word stores are done as a read-modify-write.

## Interface
- ADDR_WIDTH, 11: byte address width; matches the RAM's raddr/waddr.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- req_signed  in  1  loads only: sign-extend instead of zero-extend.
- req_addr  in  ADDR_WIDTH  byte address; any alignment is legal.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle pulse; the load result is on rsp_rdata. There is no backpressure.
- rsp_rdata  out  32  load result; holds its value until the next load.
- bram_raddr  out  ADDR_WIDTH  RAM read address.
- bram_waddr  out  ADDR_WIDTH  RAM write address.
- bram_wdata  out  32  RAM write data.
- bram_wren  out  1  RAM write enable.
- bram_out  in  32  RAM read data: the 4 bytes at raddr, little-endian, registered one cycle after raddr.

## Operation
- **FSM states:** IDLE, RD, CAP, WR.
- **req_ready** = (state == IDLE). It is purely combinational; no other output depends combinationally on req_*, except under the macro described in Configuration.
- **IDLE, on accept:** latch addr_q, size_q, signed_q, write_q and wdata_q.
  - Load or sub-word store → RD.
  - Word store → WR.
- **RD:** bram_raddr = addr_q; bram_wren = 0. → CAP.
- **CAP:** bram_out is valid in this cycle.
  - Load: at the edge, register the extracted value into rsp_rdata, set rsp_valid for the next cycle, → IDLE.
  - Sub-word store: register merged_q, → WR.
- **Extract:**
  - byte = bram_out[7:0], half = bram_out[15:0], word = bram_out.
  - Upper bits are filled with the top bit of the extracted field if signed_q, else with 0.
- **Merge:**
  - byte: {bram_out[31:8], wdata_q[7:0]}.
  - half: {bram_out[31:16], wdata_q[15:0]}.
- **WR:** bram_waddr = addr_q; bram_wdata = merged_q for sub-word stores, wdata_q for word stores; bram_wren = 1. → IDLE.
- Outside RD, bram_raddr holds addr_q. Outside WR, bram_wren = 0.
- Requests are fully serialized, so no read-after-write hazard exists. Address wrap at the top of the RAM is the RAM's concern; addresses pass through unmodified.

## Timing
- **Reset values:** state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, bram_wren = 0, bram_raddr/waddr/wdata = 0.
- **Load:** accepted at edge N; rsp_valid is high in the cycle after edge N+2. Throughput is 3 cycles.
- **Word store:** RAM write happens at edge N+1. Throughput is 2 cycles.
- **Sub-word store:** RAM write happens at edge N+3. Throughput is 4 cycles.
- **Reset mid-operation:** the FSM returns to IDLE immediately and the pending write is dropped. bram_wren deasserts asynchronously. No rsp_valid is issued for the dropped request.
- req_* inputs are ignored while req_ready = 0.

## Configuration
- **BRAM_PORT_FAST_STORE_EN defined:** in IDLE, an accepted word store drives the RAM combinationally.
  - bram_waddr = req_addr, bram_wdata = req_wdata, bram_wren = req_valid && req_write && size is word.
  - The FSM stays in IDLE, giving 1-cycle throughput and a write at edge N.
- **Not defined:** word stores go through WR as described above.

## Structure
- **bram_port_pkg** holds:
  - the size enum: SIZE_B = 0, SIZE_H = 1, SIZE_W = 2;
  - the state enum: IDLE, RD, CAP, WR;
  - the data-width constant (32).
- **Sub-module bram_port_align** is combinational and is instantiated once.
  - Inputs: bram_out, size, signed, wdata.
  - Outputs: extracted load value and merged store word.
  - The FSM and registers stay in bram_port.

## Test plan
1. **Word store then load:** store word 0x12345678 at addr 3, then load word at addr 3 → rsp_rdata = 0x12345678, with rsp_valid 2 cycles after acceptance.
2. **Byte store via RMW:** RAM[0..3] = 0xAABBCCDD; store byte 0x11 at addr 0 → bram_wdata = 0xAABBCC11 with wren at edge N+3. A following load word at addr 0 returns 0xAABBCC11.
3. **Sign extension:**
   - byte 0x80 at addr 5: signed byte load → 0xFFFFFF80; unsigned → 0x00000080.
   - half 0x8001 at addr 5: signed half load → 0xFFFF8001.
4. **Handshake:** hold req_valid for back-to-back loads → req_ready is low in RD/CAP. Exactly one rsp_valid pulse per accepted load. Requests are never lost or duplicated.
5. **Reset mid-store:** assert reset during CAP of a half store → bram_wren never asserts, RAM is unchanged, req_ready = 1 after release.
6. **BRAM_PORT_FAST_STORE_EN:** 4 consecutive word stores to addrs 0, 4, 8, 12 → 4 writes on 4 consecutive edges with req_ready constantly 1. Without the macro, the same sequence takes 8 cycles.
